// File: rtl/pubkey_serializer.sv
// SEC1 encoder for an affine public-key point: streams the point as bytes
// over a valid/ready interface (compressed, uncompressed or infinity).
module pubkey_serializer #(
  parameter bit COMPRESSED = 1'b1
) (
  input  logic         clk,
  input  logic         Reset_n,
  input  logic [511:0] in_point,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [7:0]   out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t       state_q;
  logic [511:0] shreg_q;
  logic [6:0]   cnt_q;
  logic [7:0]   out_data_q;
  logic         out_valid_q;
  logic         out_last_q;

  logic [255:0] cap_x;
  logic [255:0] cap_y;
  logic         cap_inf;
  logic [7:0]   cap_prefix;
  logic [6:0]   cap_len;

  assign cap_x      = in_point[511:256];
  assign cap_y      = in_point[255:0];
  assign cap_inf    = (cap_x == '0) && (cap_y == '0);
  assign cap_prefix = cap_inf    ? 8'h00 :
                      COMPRESSED ? {7'h01, cap_y[0]} : 8'h04;
  assign cap_len    = cap_inf    ? 7'd0 :
                      COMPRESSED ? 7'd32 : 7'd64;

  // The byte register is loaded one handshake ahead: the prefix is placed at
  // capture, and each accepted byte pulls the next one from the shift register.
  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            shreg_q     <= in_point;
            cnt_q       <= cap_len;
            out_data_q  <= cap_prefix;
            out_valid_q <= 1'b1;
            out_last_q  <= cap_inf;
            state_q     <= SEND;
          end
        end
        SEND: begin
          if (out_ready) begin
            if (cnt_q == '0) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              out_data_q  <= '0;
              state_q     <= in_valid ? HOLD : IDLE;
            end else begin
              out_data_q <= shreg_q[511:504];
              shreg_q    <= {shreg_q[503:0], 8'h00};
              cnt_q      <= cnt_q - 7'd1;
              out_last_q <= (cnt_q == 7'd1);
            end
          end
        end
        HOLD: begin
          if (!in_valid) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_pubkey_serializer.sv
module tb_pubkey_serializer;

  logic         clk;
  logic         Reset_n;
  logic [511:0] in_point;
  logic         in_valid_c, in_valid_u;
  logic         out_ready_c, out_ready_u;
  logic         in_ready_c, in_ready_u;
  logic [7:0]   out_data_c, out_data_u;
  logic         out_valid_c, out_valid_u;
  logic         out_last_c, out_last_u;
  logic         busy_c, busy_u;

  logic         sel;
  logic [7:0]   obs_data;
  logic         obs_valid, obs_last, obs_ready, obs_busy;

  int total;
  int bad;
  logic [8:0] sb[$];

  pubkey_serializer #(.COMPRESSED(1'b1)) u_c (
    .clk       (clk),
    .Reset_n   (Reset_n),
    .in_point  (in_point),
    .in_valid  (in_valid_c),
    .in_ready  (in_ready_c),
    .out_data  (out_data_c),
    .out_valid (out_valid_c),
    .out_ready (out_ready_c),
    .out_last  (out_last_c),
    .busy      (busy_c)
  );

  pubkey_serializer #(.COMPRESSED(1'b0)) u_u (
    .clk       (clk),
    .Reset_n   (Reset_n),
    .in_point  (in_point),
    .in_valid  (in_valid_u),
    .in_ready  (in_ready_u),
    .out_data  (out_data_u),
    .out_valid (out_valid_u),
    .out_ready (out_ready_u),
    .out_last  (out_last_u),
    .busy      (busy_u)
  );

  assign obs_data  = sel ? out_data_u  : out_data_c;
  assign obs_valid = sel ? out_valid_u : out_valid_c;
  assign obs_last  = sel ? out_last_u  : out_last_c;
  assign obs_ready = sel ? in_ready_u  : in_ready_c;
  assign obs_busy  = sel ? busy_u      : busy_c;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] seq(input logic [7:0] b0);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) r[8*(31-i) +: 8] = b0 + 8'(i);
    return r;
  endfunction

  // Reference SEC1 encoding pushed to the scoreboard as {last, byte}.
  task automatic push_frame(input logic [511:0] p, input bit comp);
    logic [255:0] x, y;
    int n;
    x = p[511:256];
    y = p[255:0];
    if (x == '0 && y == '0) begin
      sb.push_back({1'b1, 8'h00});
    end else begin
      sb.push_back({1'b0, comp ? (y[0] ? 8'h03 : 8'h02) : 8'h04});
      n = comp ? 32 : 64;
      for (int i = 0; i < n; i++) begin
        if (i < 32) sb.push_back({i == n - 1, x[8*(31-i) +: 8]});
        else        sb.push_back({i == n - 1, y[8*(63-i) +: 8]});
      end
    end
  endtask

  task automatic set_ready(input logic r);
    out_ready_c = sel ? 1'b0 : r;
    out_ready_u = sel ? r : 1'b0;
  endtask

  task automatic start(input bit s, input logic [511:0] p, input bit hold);
    @(negedge clk);
    sel      = s;
    in_point = p;
    if (s) in_valid_u = 1'b1;
    else   in_valid_c = 1'b1;
    push_frame(p, !s);
    @(posedge clk);
    #1;
    chk("busy_after_capture", obs_busy, 1);
    if (!hold) begin
      in_valid_c = 1'b0;
      in_valid_u = 1'b0;
    end
  endtask

  task automatic drain(input bit bp, input int n);
    int got, cyc;
    logic r, pv, pr, pl;
    logic [7:0] pd;
    logic [8:0] e;
    got = 0; cyc = 0; pv = 0; pr = 0; pd = '0; pl = 0;
    while (got < n && sb.size() != 0) begin
      @(negedge clk);
      cyc++;
      if (cyc > 3000) begin
        chk("drain_timeout", sb.size(), 0);
        sb.delete();
        break;
      end
      chk("valid", obs_valid, 1);
      if (pv && !pr) begin
        chk("hold_data", obs_data, pd);
        chk("hold_last", obs_last, pl);
      end
      r = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      set_ready(r);
      if (obs_valid && r) begin
        e = sb.pop_front();
        chk("byte", obs_data, e[7:0]);
        chk("last", obs_last, e[8]);
        got++;
      end
      pv = obs_valid; pr = r; pd = obs_data; pl = obs_last;
    end
    @(posedge clk);
    #1;
    set_ready(1'b0);
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    chk({tag, "_valid"}, obs_valid, 0);
    chk({tag, "_busy"}, obs_busy, 0);
    chk({tag, "_ready"}, obs_ready, 1);
  endtask

  logic [511:0] p_odd, p_even, p_unc;

  initial begin
    total = 0; bad = 0;
    sel = 0;
    Reset_n = 0; in_point = '0;
    in_valid_c = 0; in_valid_u = 0; out_ready_c = 0; out_ready_u = 0;
    p_odd  = {seq(8'h01), 256'h1};
    p_even = {seq(8'h01), 256'h2};
    p_unc  = {seq(8'h01), seq(8'hA0)};

    repeat (3) @(posedge clk);
    @(negedge clk);
    Reset_n = 1;
    @(negedge clk);
    chk("rst_valid_c", out_valid_c, 0);
    chk("rst_last_c", out_last_c, 0);
    chk("rst_data_c", out_data_c, 8'h00);
    chk("rst_busy_c", busy_c, 0);
    chk("rst_ready_c", in_ready_c, 1);
    chk("rst_ready_u", in_ready_u, 1);
    chk("rst_valid_u", out_valid_u, 0);

    // Compressed, odd y: 03, 01..20
    start(0, p_odd, 0);
    drain(0, 1000);
    idle_check("cmp_odd_end");

    // Uncompressed: 04, 01..20, A0..BF
    start(1, p_unc, 0);
    drain(0, 1000);
    idle_check("unc_end");

    // Compressed, even y: prefix 02
    start(0, p_even, 0);
    drain(0, 1000);
    idle_check("cmp_even_end");

    // Infinity on both variants
    start(0, '0, 0);
    drain(0, 1000);
    idle_check("inf_c_end");
    start(1, '0, 0);
    drain(0, 1000);
    idle_check("inf_u_end");

    // Random backpressure
    start(0, p_odd, 0);
    drain(1, 1000);
    idle_check("bp_end");
    start(1, p_unc, 0);
    drain(1, 1000);
    idle_check("bp_unc_end");

    // Level-held in_valid: one frame, then HOLD until it falls
    start(0, p_odd, 1);
    drain(0, 1000);
    for (int i = 0; i < 165; i++) begin
      @(negedge clk);
      chk("hold_no_valid", out_valid_c, 0);
      set_ready(1'b1);
    end
    chk("hold_ready", in_ready_c, 0);
    chk("hold_busy", busy_c, 1);
    @(negedge clk);
    set_ready(1'b0);
    in_valid_c = 0;
    @(negedge clk);
    chk("hold_exit_ready", in_ready_c, 1);
    chk("hold_exit_busy", busy_c, 0);
    start(0, p_even, 0);
    drain(0, 1000);
    idle_check("second_frame_end");

    // Reset mid-frame after byte 10
    start(0, p_odd, 0);
    drain(0, 10);
    chk("pre_rst_remaining", sb.size(), 23);
    Reset_n = 0;
    set_ready(1'b1);
    @(posedge clk);
    #1;
    Reset_n = 1;
    set_ready(1'b0);
    sb.delete();
    @(negedge clk);
    chk("midrst_valid", out_valid_c, 0);
    chk("midrst_last", out_last_c, 0);
    chk("midrst_busy", busy_c, 0);
    chk("midrst_ready", in_ready_c, 1);
    start(0, p_even, 0);
    drain(0, 1000);
    idle_check("post_rst_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pubkey_serializer.md
Name: pubkey_serializer

Overview:
- Consumes the affine public-key point produced by the scalar-multiply stage (point from its out_point, strobe from its Done) and emits it as a SEC1-encoded byte stream over a valid/ready interface.
- Feeds the downstream UART/host transmit path.
- Supports compressed encoding (33 bytes) and uncompressed encoding (65 bytes).
- Encodes the (0,0) "no point" marker as the 1-byte point-at-infinity.

Parameters:
COMPRESSED, 1, 1 = emit 0x02/0x03 prefix + X (33 bytes); 0 = emit 0x04 prefix + X + Y (65 bytes)

Ports:
clk  input  1  system clock
Reset_n  input  1  reset, synchronous, active-low
in_point  input  512 (curve_point_t: x[255:0], y[255:0])  point to encode; sampled only on input handshake
in_valid  input  1  point available; level signal, may stay high indefinitely (driven by upstream Done)
in_ready  output  1  block can accept a point
out_data  output  8  current byte
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts byte
out_last  output  1  current byte is final byte of the encoding
busy  output  1  high in any state other than IDLE

Behaviour:
- Single clock domain.
- Reset: Reset_n is synchronous, active-low. On any rising clk edge with Reset_n=0:
  - state=IDLE; out_valid=0, out_last=0, out_data=8'h00, busy=0.
  - shift register and byte counter cleared.
  - in_ready reads 1 from the first cycle after reset deasserts.
  - Reset mid-stream aborts the frame with no further bytes. Downstream sees out_valid drop without out_last.
- State machine, one-hot or encoded: IDLE, SEND, HOLD.
  - IDLE:
    - in_ready=1.
    - On in_valid&in_ready at an edge: capture in_point into the 512-bit shift register {x,y}; choose the prefix; load byte counter with total length-1; go to SEND.
  - SEND:
    - out_valid=1; out_data = current byte; in_ready=0.
    - Byte advances only on out_valid&out_ready.
    - out_data, out_last and the held point are stable while out_valid&!out_ready.
  - HOLD:
    - Entered after the final-byte handshake if in_valid is still 1.
    - in_ready=0, out_valid=0.
    - Returns to IDLE on the first cycle in_valid=0.
    - Prevents re-encoding the same level-held Done.
  - After the final-byte handshake, go directly to IDLE if in_valid=0 in that cycle.
- Encoding:
  - Infinity: x==0 && y==0 → single byte 8'h00 with out_last=1. Applies regardless of COMPRESSED.
  - COMPRESSED=1: prefix 8'h02 if y[0]==0, 8'h03 if y[0]==1; then x[255:248] … x[7:0]. 33 bytes total.
  - COMPRESSED=0: prefix 8'h04; then X MSB-first, then Y MSB-first. 65 bytes total.
- Prefix and infinity decisions are computed from in_point at capture and registered. No later dependence on in_point.
- Latency: first byte (prefix) has out_valid=1 in the cycle after the capture edge.
- Throughput: with out_ready held 1, one byte per cycle. Frame completes 33 (or 65) cycles after capture.
- Byte counter: 7 bits, decrements per accepted byte after the prefix. out_last = (counter==0) in SEND. No wrap: a counter of 0 with handshake always exits SEND.
- Shift register shifts left 8 bits per accepted data byte; out_data for data bytes = shift_reg[511:504].
- out_ready during IDLE/HOLD is ignored.
- in_point changes during SEND are ignored.
- A new point is accepted no sooner than one cycle after leaving HOLD/SEND (IDLE must be visited).

Test Plan:
- Compressed, y odd: x = bytes 8'h01..8'h20 MSB-first, y=256'h1, in_valid pulse 1 cycle, out_ready=1.
  → bytes 03,01,02,…,20; out_last only on 20; 33 consecutive valid cycles starting 1 cycle after capture; then IDLE, in_ready=1.
- COMPRESSED=0, same x, y = bytes 8'hA0..8'hBF.
  → 04, 01..20, A0..BF; 65 bytes; out_last on BF.
  - Same point with y=256'h2 under COMPRESSED=1 → prefix 02.
- Infinity: in_point=(0,0).
  → one byte 00 with out_valid=1, out_last=1; done after 1 handshake.
- Backpressure: out_ready toggles 1,0,0,1,… (random).
  → out_data/out_last hold steady while out_ready=0; byte sequence identical to the first test; no bytes dropped or duplicated.
- Level-held in_valid: in_valid stuck 1 for 200 cycles.
  → exactly one frame emitted; block sits in HOLD with in_ready=0 until in_valid falls; next rise of in_valid yields a second frame.
- Reset mid-frame: Reset_n=0 for 1 cycle after byte 10.
  → next cycle out_valid=0, busy=0, in_ready=1; a fresh point then encodes from its prefix correctly.
